// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response channel between the load/store unit and the data memory controller
interface dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  modport master (
    output req_valid, req_we, req_mode, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
  modport slave (
    input  req_valid, req_we, req_mode, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: handshaked byte-addressable data memory with wait states, error reporting and post-reset clear
module dmem_ctrl #(
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 1,
  parameter bit BIG_ENDIAN = 1
) (
  input logic        clk,
  input logic        reset,
  dmem_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {CLEAR, IDLE, WAIT, EXEC, RESP} state_t;
  state_t state, nxt;
  logic [7:0]    mem [DEPTH];
  logic          we;
  logic [2:0]    mode;
  logic [31:0]   addr, wdata;
  logic [3:0]    cnt;
  logic [AW-1:0] clr;
  logic          is_h, is_b, is_w, err;
  logic [AW-1:0] la [4];
  logic [7:0]    b [4];
  logic [3:0]    wen;
  logic [31:0]   ws, w, rd;
  logic [15:0]   h16;
  assign is_h = mode[1:0] == 2'b01;
  assign is_b = mode[1:0] == 2'b10;
  assign is_w = !is_h && !is_b;
  assign err  = (is_w && addr[1:0] != 2'b00) || (is_h && addr[0]) || (addr >= 32'(DEPTH));
  assign bus.req_ready = state == IDLE;
  assign bus.busy      = state != IDLE;
  // state register; reset always restarts the clear sequence
  always_ff @(posedge clk)
    state <= reset ? CLEAR : nxt;
  // next-state decode
  always_comb begin
    nxt = state;
    case (state)
      CLEAR:   nxt = clr == AW'(DEPTH - 4) ? IDLE : CLEAR;
      IDLE:    nxt = bus.req_valid ? (LATENCY == 0 ? EXEC : WAIT) : IDLE;
      WAIT:    nxt = cnt == 4'd1 ? EXEC : WAIT;
      EXEC:    nxt = RESP;
      RESP:    nxt = bus.rsp_ready ? IDLE : RESP;
      default: nxt = CLEAR;
    endcase
  end
  // lane addressing, byte-order swizzle of store data and assembly/extension of load data
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      la[i] = (state == CLEAR ? clr : addr[AW-1:0]) | AW'(i);
      b[i]  = mem[la[i]];
    end
    ws  = (!BIG_ENDIAN || is_b) ? wdata
        : is_w ? {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]}
        : {16'h0, wdata[7:0], wdata[15:8]};
    h16 = BIG_ENDIAN ? {b[0], b[1]} : {b[1], b[0]};
    w   = BIG_ENDIAN ? {b[0], b[1], b[2], b[3]} : {b[3], b[2], b[1], b[0]};
    rd  = is_b ? {{24{mode[2] & b[0][7]}}, b[0]}
        : is_h ? {{16{mode[2] & h16[15]}}, h16} : w;
    wen = reset ? 4'h0
        : state == CLEAR ? 4'hF
        : (state == EXEC && we && !err) ? (is_w ? 4'hF : is_h ? 4'h3 : 4'h1) : 4'h0;
  end
  // byte-lane write port shared by the clear sequence and committed stores
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (wen[i]) mem[la[i]] <= state == CLEAR ? 8'h0 : ws[8*i +: 8];
  // request latch, wait counter, clear index and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      clr           <= '0;
      cnt           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      if (state == CLEAR) clr <= clr + AW'(4);
      if (state == IDLE && bus.req_valid) begin
        we    <= bus.req_we;
        mode  <= bus.req_mode;
        addr  <= bus.req_addr;
        wdata <= bus.req_wdata;
        cnt   <= 4'(LATENCY);
      end
      if (state == WAIT) cnt <= cnt - 4'd1;
      if (state == EXEC) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= err;
        bus.rsp_rdata <= (we || err) ? 32'h0 : rd;
      end
      if (state == RESP && bus.rsp_ready) bus.rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed checks of a big-endian LATENCY=1 and a little-endian LATENCY=3 controller
module tb_dmem_ctrl;
  logic        clk = 0, reset = 1, sel = 0;
  logic        req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [2:0]  req_mode = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        rdy, vld, err, busy;
  logic [31:0] rdata;
  int          checks = 0, fails = 0;
  always #5 clk = ~clk;
  dmem_ctrl_if a_if ();
  dmem_ctrl_if b_if ();
  assign a_if.req_valid = req_valid & ~sel;
  assign b_if.req_valid = req_valid & sel;
  assign a_if.rsp_ready = rsp_ready & ~sel;
  assign b_if.rsp_ready = rsp_ready & sel;
  assign a_if.req_we = req_we;
  assign b_if.req_we = req_we;
  assign a_if.req_mode = req_mode;
  assign b_if.req_mode = req_mode;
  assign a_if.req_addr = req_addr;
  assign b_if.req_addr = req_addr;
  assign a_if.req_wdata = req_wdata;
  assign b_if.req_wdata = req_wdata;
  assign rdy   = sel ? b_if.req_ready : a_if.req_ready;
  assign vld   = sel ? b_if.rsp_valid : a_if.rsp_valid;
  assign err   = sel ? b_if.rsp_err   : a_if.rsp_err;
  assign busy  = sel ? b_if.busy      : a_if.busy;
  assign rdata = sel ? b_if.rsp_rdata : a_if.rsp_rdata;
  dmem_ctrl u_a (.clk(clk), .reset(reset), .bus(a_if.slave));
  dmem_ctrl #(.DEPTH(256), .LATENCY(3), .BIG_ENDIAN(0)) u_b (.clk(clk), .reset(reset), .bus(b_if.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    int n;
    logic saw;
    @(negedge clk) reset = 1;
    @(negedge clk);
    chk("rst_rdy", 32'(rdy), 0);
    chk("rst_vld", 32'(vld), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", 32'(err), 0);
    reset = 0;
    n = 0;
    saw = 0;
    while (busy && n < 300) begin
      saw |= vld;
      n++;
      @(negedge clk);
    end
    chk("clr_cycles", n, 64);
    chk("clr_ready", 32'(rdy), 1);
    chk("clr_novld", 32'(saw), 0);
  endtask

  task automatic xfer(input string tag, input logic we, input logic [2:0] mode, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err, input int hold);
    int n, lat;
    @(negedge clk);
    req_we = we; req_mode = mode; req_addr = addr; req_wdata = wd; req_valid = 1;
    n = 0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!vld && lat < 50);
    chk({tag, "_lat"}, lat, sel ? 5 : 3);
    chk({tag, "_rd"}, rdata, exp_rd);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_vld"}, 32'(vld), 1);
      chk({tag, "_hold_rd"}, rdata, exp_rd);
      chk({tag, "_hold_rdy"}, 32'(rdy), 0);
    end
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    @(negedge clk);
    chk({tag, "_idle"}, 32'(rdy), 1);
  endtask

  initial begin
    do_reset();
    sel = 0;
    xfer("lw00", 0, 3'b000, 32'h00, 0, 32'h0, 0, 0);
    xfer("lw7c", 0, 3'b000, 32'h7C, 0, 32'h0, 0, 0);
    xfer("lwfc", 0, 3'b000, 32'hFC, 0, 32'h0, 0, 0);
    xfer("sw10", 1, 3'b000, 32'h10, 32'h12345678, 32'h0, 0, 0);
    xfer("lw10", 0, 3'b000, 32'h10, 0, 32'h12345678, 0, 0);
    xfer("lbu10", 0, 3'b010, 32'h10, 0, 32'h00000012, 0, 0);
    xfer("sb11", 1, 3'b010, 32'h11, 32'hFFFFFF5A, 32'h0, 0, 0);
    xfer("lw10m3", 0, 3'b011, 32'h10, 0, 32'h125A5678, 0, 0);
    xfer("sh22", 1, 3'b001, 32'h22, 32'hAAAA80F1, 32'h0, 0, 0);
    xfer("lh22", 0, 3'b101, 32'h22, 0, 32'hFFFF80F1, 0, 0);
    xfer("lhu22", 0, 3'b001, 32'h22, 0, 32'h000080F1, 0, 0);
    xfer("lb23", 0, 3'b110, 32'h23, 0, 32'hFFFFFFF1, 0, 0);
    xfer("lbu20", 0, 3'b010, 32'h20, 0, 32'h0, 0, 0);
    xfer("lbu21", 0, 3'b010, 32'h21, 0, 32'h0, 0, 0);
    xfer("lw13", 0, 3'b000, 32'h13, 0, 32'h0, 1, 0);
    xfer("sh21", 1, 3'b001, 32'h21, 32'h1234, 32'h0, 1, 0);
    xfer("lw100", 0, 3'b000, 32'h100, 0, 32'h0, 1, 0);
    xfer("lw20", 0, 3'b000, 32'h20, 0, 32'h000080F1, 0, 0);
    sel = 1;
    xfer("le_sw10", 1, 3'b000, 32'h10, 32'h12345678, 32'h0, 0, 0);
    xfer("le_lw10", 0, 3'b000, 32'h10, 0, 32'h12345678, 0, 5);
    xfer("le_lbu10", 0, 3'b010, 32'h10, 0, 32'h00000078, 0, 0);
    xfer("le_sh22", 1, 3'b001, 32'h22, 32'h000080F1, 32'h0, 0, 0);
    xfer("le_lb23", 0, 3'b110, 32'h23, 0, 32'hFFFFFF80, 0, 0);
    xfer("le_lh22", 0, 3'b101, 32'h22, 0, 32'hFFFF80F1, 0, 0);
    xfer("le_lw20", 0, 3'b000, 32'h20, 0, 32'h80F10000, 0, 0);
    @(negedge clk);
    req_we = 1; req_mode = 3'b000; req_addr = 32'h40; req_wdata = 32'hDEADBEEF; req_valid = 1;
    chk("wr_rdy", 32'(rdy), 1);
    @(posedge clk);
    #1 req_valid = 0;
    do_reset();
    xfer("le_lw40", 0, 3'b000, 32'h40, 0, 32'h0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
